// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producer arbiter and the async FIFO write port.
// master: the arbiter; slave: producers plus FIFO full flag (bench side).
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  full;
    logic                  wr_en;
    logic [WIDTH-1:0]      data_in;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        input  req, req_data, full,
        output ack, wr_en, data_in, grant_id, busy
    );

    modport slave (
        output req, req_data, full,
        input  ack, wr_en, data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (wr_clk domain).
// Optional FIFO_ARB_STAT_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic        wr_clk,
    input  logic        wr_rst,
`ifdef FIFO_ARB_STAT_EN
    output logic [15:0] stall_cnt,
`endif
    fifo_wr_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BURST) + 1;

    typedef enum logic {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic            hold_req;
    logic            write;

    // Scan downwards so the closest requester after last_q wins the overwrite.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (bus.req[cand]) pick = cand;
        end
    end

    assign hold_req = bus.req[grant_q];
    assign write    = (state_q == StBurst) && hold_req && !bus.full;

    always_comb begin
        bus.ack          = '0;
        bus.ack[grant_q] = write;
        bus.wr_en        = write;
        bus.busy         = (state_q == StBurst);
        bus.grant_id     = grant_q;
        bus.data_in      = '0;
        if (state_q == StBurst) bus.data_in = bus.req_data[grant_q*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (!hold_req) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (write) begin
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_ARB_STAT_EN
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            stall_cnt <= '0;
        end else if ((state_q == StBurst) && hold_req && bus.full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer word queues drive req/req_data,
// expected words, grants and {busy,wr_en} sequences are compared as the DUT writes.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int BURST = 4;

    logic wr_clk = 1'b0;
    logic wr_rst;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
`ifdef FIFO_ARB_STAT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
`ifdef FIFO_ARB_STAT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;

    logic [WIDTH-1:0] word_q [NREQ][$];
    logic [WIDTH-1:0] exp_q  [NREQ][$];
    logic [WIDTH-1:0] fifo_m [$];
    int               grant_exp [$];
    logic [1:0]       bw_exp [$];
    logic             full_sched [$];
    logic [NREQ-1:0]  ack_seen = '0;
    logic             rst_req;
    bit               fifo_mode = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load(input int p, input logic [WIDTH-1:0] w);
        word_q[p].push_back(w);
        exp_q[p].push_back(w);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (word_q[i].size() != 0) return 0;
        return 1;
    endfunction

    // One cycle: retire last cycle's acks, drive inputs at negedge, sample #1 later.
    task automatic step();
        int g;
        @(negedge wr_clk);
        for (int i = 0; i < NREQ; i++)
            if (ack_seen[i] && word_q[i].size() > 0) void'(word_q[i].pop_front());
        ack_seen = '0;
        wr_rst = rst_req;
        if (fifo_mode) begin
            if (fifo_m.size() > 0 && $urandom_range(0, 2) == 0) void'(fifo_m.pop_front());
            bus.full = (fifo_m.size() >= 8) || ($urandom_range(0, 3) == 0);
        end else begin
            bus.full = (full_sched.size() > 0) ? full_sched.pop_front() : 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i] = (word_q[i].size() > 0);
            bus.req_data[i*WIDTH +: WIDTH] = (word_q[i].size() > 0) ? word_q[i][0] : '0;
        end
        #1;
        if (bw_exp.size() > 0) check("busy_wren", 32'({bus.busy, bus.wr_en}), 32'(bw_exp.pop_front()));
        if (bus.full) check("no_write_full", 32'(bus.wr_en), 32'(0));
        if (bus.wr_en) begin
            n_wr++;
            g = int'(bus.grant_id);
            check("ack_onehot", 32'(bus.ack), 32'(1) << g);
            if (grant_exp.size() > 0) check("grant", 32'(g), 32'(grant_exp.pop_front()));
            if (exp_q[g].size() > 0) check("data", 32'(bus.data_in), 32'(exp_q[g].pop_front()));
            else check("unexp_write", 32'(1), 32'(0));
            if (fifo_mode) begin
                fifo_m.push_back(bus.data_in);
                check("fifo_ovf", 32'(fifo_m.size() <= 8), 32'(1));
            end
            ack_seen = bus.ack;
        end else begin
            check("ack_idle", 32'(bus.ack), 32'(0));
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        bit done = 0;
        for (int c = 0; c < max && !done; c++) begin
            step();
            done = all_empty() && (bw_exp.size() == 0) && !bus.busy;
        end
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_grants_left"}, 32'(grant_exp.size()), 32'(0));
        for (int i = 0; i < NREQ; i++) check({tag, "_exp_left"}, 32'(exp_q[i].size()), 32'(0));
    endtask

    task automatic push_bw(input int n, input logic [1:0] v);
        for (int i = 0; i < n; i++) bw_exp.push_back(v);
    endtask

    task automatic push_grant(input int n, input int g);
        for (int i = 0; i < n; i++) grant_exp.push_back(g);
    endtask

    initial begin
        // Reset with every requester active; then continuous round robin.
        wr_rst       = 1'b1;
        rst_req      = 1'b1;
        bus.full     = 1'b0;
        bus.req      = '1;
        bus.req_data = '0;
        #1;
        check("rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("rst_ack", 32'(bus.ack), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        for (int p = 0; p < NREQ; p++)
            for (int k = 0; k < 8; k++) load(p, WIDTH'((p * 4 + k) % 16));
        push_bw(2, 2'b00);
        step();
        step();
        rst_req = 1'b0;
        push_bw(1, 2'b00);
        push_bw(1, 2'b11);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NREQ; p++) push_grant(BURST, p);
        n_wr = 0;
        run_idle("t3", 300);
        check("t3_writes", 32'(n_wr), 32'(32));

        // Single requester, 6 words: burst of 4, idle gap, 2 more.
        n_wr = 0;
        for (int k = 0; k < 6; k++) load(2, 4'h9);
        push_grant(6, 2);
        push_bw(1, 2'b00); push_bw(4, 2'b11); push_bw(1, 2'b00);
        push_bw(2, 2'b11); push_bw(1, 2'b10); push_bw(1, 2'b00);
        run_idle("t2", 100);
        check("t2_writes", 32'(n_wr), 32'(6));

        // full held for 5 cycles after two writes of a burst.
        n_wr = 0;
        for (int k = 0; k < 4; k++) load(1, WIDTH'(10 + k));
        push_grant(4, 1);
        for (int i = 0; i < 3; i++) full_sched.push_back(1'b0);
        for (int i = 0; i < 5; i++) full_sched.push_back(1'b1);
        push_bw(1, 2'b00); push_bw(2, 2'b11); push_bw(5, 2'b10);
        push_bw(2, 2'b11); push_bw(1, 2'b00);
        run_idle("t4", 100);
        check("t4_writes", 32'(n_wr), 32'(4));
`ifdef FIFO_ARB_STAT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(5));
`endif

        // Holders drop req after 2 writes; rotation continues 2 -> 3 -> 0.
        n_wr = 0;
        load(2, 4'h1); load(2, 4'h2);
        load(3, 4'h3); load(3, 4'h4);
        load(0, 4'h5); load(0, 4'h6);
        push_grant(2, 2); push_grant(2, 3); push_grant(2, 0);
        for (int r = 0; r < 3; r++) begin
            push_bw(1, 2'b00); push_bw(2, 2'b11); push_bw(1, 2'b10);
        end
        push_bw(1, 2'b00);
        run_idle("t5", 100);
        check("t5_writes", 32'(n_wr), 32'(6));

        // Reset mid-burst: rotation restarts from requester 0.
        n_wr = 0;
        load(2, 4'h7); load(2, 4'h8); load(2, 4'hE);
        push_grant(1, 2);
        push_bw(1, 2'b00); push_bw(1, 2'b11);
        step();
        step();
        rst_req = 1'b1;
        load(0, 4'hB); load(0, 4'hC); load(0, 4'hD);
        push_bw(1, 2'b00);
        step();
        rst_req = 1'b0;
        push_grant(3, 0); push_grant(2, 2);
        push_bw(1, 2'b00); push_bw(3, 2'b11); push_bw(1, 2'b10);
        push_bw(1, 2'b00); push_bw(2, 2'b11); push_bw(1, 2'b10); push_bw(1, 2'b00);
        run_idle("trst", 100);
        check("trst_writes", 32'(n_wr), 32'(6));

        // Depth-8 FIFO model with random drain and full toggling.
        n_wr = 0;
        fifo_mode = 1;
        for (int p = 0; p < NREQ; p++)
            for (int k = 0; k < 5; k++) load(p, WIDTH'((p * 5 + k) % 16));
        run_idle("t6", 3000);
        check("t6_writes", 32'(n_wr), 32'(20));
        fifo_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
